// File: rtl/dmem_responder.sv
// RV32I data-memory responder: byte-steered RAM plus optional MMIO window (TX FIFO, CYCLE) built when DMEM_MMIO_EN is defined.
// Loads return one cycle after the address is sampled; a TX push into a full FIFO is dropped (sticky overflow) unless a pop frees a slot that cycle.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 15,
    parameter int FIFO_LOG2  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dmemaddr,
    input  logic [2:0]  dmemop,
    input  logic        dmemwe,
    input  logic [31:0] dmemdatain,
    output logic [31:0] dmemdataout,
    output logic        dmemerr,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int RAM_WORDS = 1 << DEPTH_LOG2;

    logic [31:0]           ram_q [RAM_WORDS];
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic                  op_valid;
    logic                  op_half;
    logic                  op_word;
    logic                  misaligned;
    logic                  mmio_sel;
    logic [31:0]           mmio_rdata;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [31:0]           ram_wdata;
    logic [31:0]           rd_word;
    logic [31:0]           rd_shift;
    logic [31:0]           dmemdataout_q;
    logic [31:0]           dmemdataout_d;
    logic                  dmemerr_q;
    logic                  dmemerr_d;
    logic                  unused_inputs;

    // Upper address bits alias; tx_ready is only consumed by the FIFO.
    assign unused_inputs = ^{tx_ready, dmemaddr};

    always_comb begin
        op_valid = 1'b0;
        case (dmemop)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: op_valid = 1'b1;
            default:                                op_valid = 1'b0;
        endcase
    end

    assign op_half    = (dmemop[1:0] == 2'b01);
    assign op_word    = (dmemop == 3'b010);
    assign misaligned = (op_half && dmemaddr[0]) || (op_word && (dmemaddr[1:0] != 2'b00));
    assign ram_idx    = dmemaddr[DEPTH_LOG2+1:2];
    assign ram_we     = reset && dmemwe && op_valid && !misaligned && !mmio_sel;

    always_comb begin
        ram_be    = 4'b0000;
        ram_wdata = dmemdatain;
        if (op_word) begin
            ram_be = 4'b1111;
        end else if (op_half) begin
            ram_be    = dmemaddr[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{dmemdatain[15:0]}};
        end else begin
            ram_be    = 4'b0001 << dmemaddr[1:0];
            ram_wdata = {4{dmemdatain[7:0]}};
        end
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_be[i]) begin
                    ram_q[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read data comes from pre-edge state, so a same-cycle write is not visible.
    assign rd_word  = mmio_sel ? mmio_rdata : ram_q[ram_idx];
    assign rd_shift = rd_word >> {dmemaddr[1:0], 3'b000};

    always_comb begin
        dmemdataout_d = 32'h0;
        if (op_valid && !misaligned) begin
            case (dmemop)
                3'b000:  dmemdataout_d = {{24{rd_shift[7]}}, rd_shift[7:0]};
                3'b001:  dmemdataout_d = {{16{rd_shift[15]}}, rd_shift[15:0]};
                3'b100:  dmemdataout_d = {24'h0, rd_shift[7:0]};
                3'b101:  dmemdataout_d = {16'h0, rd_shift[15:0]};
                default: dmemdataout_d = rd_shift;
            endcase
        end
        dmemerr_d = dmemerr_q | misaligned;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dmemdataout_q <= 32'h0;
            dmemerr_q     <= 1'b0;
        end else begin
            dmemdataout_q <= dmemdataout_d;
            dmemerr_q     <= dmemerr_d;
        end
    end

    assign dmemdataout = dmemdataout_q;
    assign dmemerr     = dmemerr_q;

`ifdef DMEM_MMIO_EN
    localparam int FIFO_DEPTH = 1 << FIFO_LOG2;

    logic [7:0]         fifo_q [FIFO_DEPTH];
    logic [FIFO_LOG2:0] wr_ptr_q;
    logic [FIFO_LOG2:0] wr_ptr_d;
    logic [FIFO_LOG2:0] rd_ptr_q;
    logic [FIFO_LOG2:0] rd_ptr_d;
    logic [FIFO_LOG2:0] fifo_count;
    logic               overflow_q;
    logic               overflow_d;
    logic [31:0]        cycle_q;
    logic [31:0]        cycle_d;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               push_ok;
    logic [31:0]        status_word;

    assign mmio_sel   = (dmemaddr[31:16] == 16'hFFFF);
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_full  = (fifo_count == (FIFO_LOG2+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q[FIFO_LOG2-1:0]];
    assign pop        = tx_valid && tx_ready;
    assign push       = reset && dmemwe && op_valid && !misaligned && mmio_sel
                        && (dmemaddr[15:2] == 14'd0);
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok    = push && (!fifo_full || pop);

    always_comb begin
        status_word                 = 32'h0;
        status_word[0]              = fifo_full;
        status_word[1]              = fifo_empty;
        status_word[FIFO_LOG2+2:2]  = fifo_count;
        status_word[7]              = overflow_q;
        case (dmemaddr[15:2])
            14'd1:   mmio_rdata = status_word;
            14'd2:   mmio_rdata = cycle_q;
            default: mmio_rdata = 32'h0;
        endcase
        wr_ptr_d   = wr_ptr_q + {{FIFO_LOG2{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{FIFO_LOG2{1'b0}}, pop};
        overflow_d = overflow_q | (push && !push_ok);
        cycle_d    = cycle_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q[FIFO_LOG2-1:0]] <= dmemdatain[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            cycle_q    <= 32'h0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            cycle_q    <= cycle_d;
        end
    end
`else
    localparam int unused_fifo_log2 = FIFO_LOG2;

    assign mmio_sel   = 1'b0;
    assign mmio_rdata = 32'h0;
    assign tx_valid   = 1'b0;
    assign tx_data    = 8'h00;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM store/load steering, misalignment, reset, and the MMIO window when built.
module tb_dmem_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dmemaddr;
    logic [2:0]  dmemop;
    logic        dmemwe;
    logic [31:0] dmemdatain;
    logic [31:0] dmemdataout;
    logic        dmemerr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dmem_responder dut (
        .clock       (clock),
        .reset       (reset),
        .dmemaddr    (dmemaddr),
        .dmemop      (dmemop),
        .dmemwe      (dmemwe),
        .dmemdatain  (dmemdatain),
        .dmemdataout (dmemdataout),
        .dmemerr     (dmemerr),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dmemwe     = 1'b0;
        dmemaddr   = 32'h0;
        dmemop     = 3'b010;
        dmemdatain = 32'h0;
    endtask

    task automatic store(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d);
        dmemwe     = 1'b1;
        dmemaddr   = a;
        dmemop     = op;
        dmemdatain = d;
        tick();
        idle();
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] op);
        dmemwe   = 1'b0;
        dmemaddr = a;
        dmemop   = op;
        tick();
        idle();
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] c1;
        reset    = 1'b0;
        tx_ready = 1'b0;
        idle();
        tick();
        tick();
        check("rst_dataout", dmemdataout, 32'h0);
        check("rst_err", {31'h0, dmemerr}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        reset = 1'b1;

        store(32'h100, 3'b010, 32'h8765_4321);
        load(32'h103, 3'b000); check("lb_103", dmemdataout, 32'hFFFF_FF87);
        load(32'h103, 3'b100); check("lbu_103", dmemdataout, 32'h0000_0087);
        load(32'h102, 3'b001); check("lh_102", dmemdataout, 32'hFFFF_8765);
        load(32'h102, 3'b101); check("lhu_102", dmemdataout, 32'h0000_8765);
        load(32'h100, 3'b010); check("lw_100", dmemdataout, 32'h8765_4321);
        load(32'h100, 3'b000); check("lb_100", dmemdataout, 32'h0000_0021);

        store(32'h100, 3'b010, 32'h1122_3344);
        store(32'h101, 3'b000, 32'hFFFF_FFAA);
        load(32'h100, 3'b010); check("sb_101", dmemdataout, 32'h1122_AA44);
        store(32'h102, 3'b001, 32'h1234_BEEF);
        load(32'h100, 3'b010); check("sh_102", dmemdataout, 32'hBEEF_AA44);

        // Store and load of the same word in one cycle.
        dmemwe     = 1'b1;
        dmemaddr   = 32'h100;
        dmemop     = 3'b010;
        dmemdatain = 32'hCAFE_F00D;
        tick();
        idle();
        check("rdw_old", dmemdataout, 32'hBEEF_AA44);
        load(32'h100, 3'b010); check("raw_new", dmemdataout, 32'hCAFE_F00D);
        load(32'h100, 3'b000); check("lb_0d", dmemdataout, 32'h0000_000D);
        load(32'h100, 3'b001); check("lh_f00d", dmemdataout, 32'hFFFF_F00D);

        store(32'h100, 3'b011, 32'h0);
        load(32'h100, 3'b010); check("undef_store", dmemdataout, 32'hCAFE_F00D);
        load(32'h100, 3'b110); check("undef_ld110", dmemdataout, 32'h0);
        load(32'h100, 3'b111); check("undef_ld111", dmemdataout, 32'h0);
        check("undef_no_err", {31'h0, dmemerr}, 32'h0);

        store(32'h200, 3'b010, 32'h0102_0304);
        check("err_clear", {31'h0, dmemerr}, 32'h0);
        store(32'h201, 3'b001, 32'h0000_FFFF);
        check("err_set", {31'h0, dmemerr}, 32'h1);
        load(32'h200, 3'b010); check("mis_st_supp", dmemdataout, 32'h0102_0304);
        load(32'h202, 3'b010); check("mis_lw_zero", dmemdataout, 32'h0);
        load(32'h203, 3'b001); check("mis_lh_zero", dmemdataout, 32'h0);
        check("err_sticky", {31'h0, dmemerr}, 32'h1);
        reset_pulse();
        check("err_rst", {31'h0, dmemerr}, 32'h0);
        check("dout_rst", dmemdataout, 32'h0);
        load(32'h200, 3'b010); check("ram_kept", dmemdataout, 32'h0102_0304);

        store(32'h300, 3'b010, 32'h1234_5678);
        reset      = 1'b0;
        dmemwe     = 1'b1;
        dmemaddr   = 32'h300;
        dmemop     = 3'b010;
        dmemdatain = 32'h0000_0055;
        tick();
        idle();
        reset = 1'b1;
        load(32'h300, 3'b010); check("rst_st_drop", dmemdataout, 32'h1234_5678);

        store(32'h0002_0104, 3'b010, 32'hA5A5_0001);
        load(32'h104, 3'b010); check("alias_hi", dmemdataout, 32'hA5A5_0001);

`ifdef DMEM_MMIO_EN
        load(32'hFFFF_0004, 3'b010); check("st_empty", dmemdataout, 32'h0000_0002);
        for (int i = 0; i < 5; i++) store(32'hFFFF_0000, 3'b010, 32'h41 + i);
        load(32'hFFFF_0004, 3'b010); check("st_full_ovf", dmemdataout, 32'h0000_0091);
        load(32'hFFFF_0000, 3'b010); check("txdata_ld", dmemdataout, 32'h0);
        check("tx_valid_full", {31'h0, tx_valid}, 32'h1);
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", {24'h0, tx_data}, 32'h41 + i);
            check("drain_valid", {31'h0, tx_valid}, 32'h1);
            tick();
        end
        check("drained_valid", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        load(32'hFFFF_0004, 3'b010); check("st_drained", dmemdataout, 32'h0000_0082);

        reset_pulse();
        for (int i = 0; i < 4; i++) store(32'hFFFF_0000, 3'b010, 32'h41 + i);
        tx_ready = 1'b1;
        store(32'hFFFF_0000, 3'b010, 32'h58);
        tx_ready = 1'b0;
        load(32'hFFFF_0004, 3'b010); check("full_pushpop", dmemdataout, 32'h0000_0011);
        check("head_after_pp", {24'h0, tx_data}, 32'h42);

        load(32'hFFFF_0008, 3'b010);
        c1 = dmemdataout;
        for (int i = 0; i < 9; i++) tick();
        load(32'hFFFF_0008, 3'b010); check("cycle_delta", dmemdataout, c1 + 32'd10);

        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
        tick();
        tick();
        tick();
        load(32'hFFFF_0008, 3'b010); check("cycle_wrap", dmemdataout, 32'h0000_0001);
`else
        store(32'hFFFF_0000, 3'b010, 32'hDEAD_BEEF);
        check("no_mmio_valid", {31'h0, tx_valid}, 32'h0);
        check("no_mmio_data", {24'h0, tx_data}, 32'h0);
        load(32'h0001_0000, 3'b010); check("no_mmio_alias", dmemdataout, 32'hDEAD_BEEF);
        tx_ready = 1'b1;
        tick();
        check("no_mmio_ready", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
